// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute controller for the 8-bit CPU core.
// Reads the instruction bytes presented by pram, drives the program counter
// (advance or jump) and the ALU (operands, op, start pulse). It holds the
// R0-R3 register file and the Z/C flags.
//
// Optional feature: define SEQ_SINGLE_STEP_EN to add a 'step' input. NEXT
// then waits for a rising edge of step before it issues its PC pulse.
//
// Handshake: none of the interfaces back-pressure. Every *_en / *_valid /
// pc_adv output is a single-cycle pulse that its consumer must accept.
// alu_res/flags are trusted ALU_LAT cycles after alu_en. pram bytes are
// trusted FETCH_WAIT cycles after a PC update.
module cpu_sequencer #(
    parameter int FETCH_WAIT = 1,
    parameter int ALU_LAT    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       load_done,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic [7:0] instr_b0,
    input  logic [7:0] instr_b1,
    input  logic [7:0] alu_res,
    input  logic       alu_carry,
    input  logic       alu_zero,
    output logic       pc_adv,
    output logic [1:0] pc_instr_size,
    output logic       pc_jump_en,
    output logic [7:0] pc_jump_addr,
    output logic       alu_en,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       busy,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_ALU_WAIT,
        S_WB,
        S_NEXT,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_MOV = 4'h2;
    localparam logic [3:0] OP_ALU = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JZ  = 4'h5;
    localparam logic [3:0] OP_JC  = 4'h6;
    localparam logic [3:0] OP_OUT = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] FETCH_LAST = 2'(FETCH_WAIT - 1);
    localparam logic [1:0] ALU_LAST   = 2'(ALU_LAT - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       start_q, start_d;
    logic [7:0] ir0_q, ir0_d;
    logic [7:0] ir1_q, ir1_d;
    logic [7:0] regs_q [4];
    logic [7:0] regs_d [4];
    logic       z_q, z_d;
    logic       c_q, c_d;
    logic       illegal_q, illegal_d;

    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [1:0] instr_size;
    logic       take_jump;
    logic       start_rise;
    logic       step_go;

    assign opcode = ir0_q[7:4];
    assign rd     = ir0_q[3:2];
    assign rs     = ir0_q[1:0];

    // Instruction size and branch decision for the latched instruction.
    always_comb begin
        instr_size = 2'd1;
        take_jump  = 1'b0;
        case (opcode)
            OP_LDI, OP_ALU: instr_size = 2'd2;
            OP_JMP: begin
                instr_size = 2'd2;
                take_jump  = 1'b1;
            end
            OP_JZ: begin
                instr_size = 2'd2;
                take_jump  = z_q;
            end
            OP_JC: begin
                instr_size = 2'd2;
                take_jump  = c_q;
            end
            default: instr_size = 2'd1;
        endcase
    end

    assign start_rise = start & ~start_q;
    assign start_d    = start;

`ifdef SEQ_SINGLE_STEP_EN
    logic step_q;
    // A step edge is only consumed in NEXT; it counts from NEXT's first cycle.
    assign step_go = step & ~step_q;

    // Step edge detector register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end
`else
    assign step_go = 1'b1;
`endif

    // Next-state, register-file update and output pulse generation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ir0_d         = ir0_q;
        ir1_d         = ir1_q;
        regs_d        = regs_q;
        z_d           = z_q;
        c_d           = c_q;
        illegal_d     = illegal_q;
        pc_adv        = 1'b0;
        pc_instr_size = 2'd0;
        pc_jump_en    = 1'b0;
        pc_jump_addr  = 8'h00;
        alu_en        = 1'b0;
        out_data      = 8'h00;
        out_valid     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Start edges with no program loaded are simply dropped.
                if (start_rise && load_done) begin
                    state_d = S_FETCH;
                    cnt_d   = 2'd0;
                end
            end
            S_FETCH: begin
                if (cnt_q == FETCH_LAST) begin
                    state_d = S_DECODE;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_DECODE: begin
                ir0_d   = instr_b0;
                ir1_d   = instr_b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_NEXT;
                case (opcode)
                    OP_NOP, OP_JMP, OP_JZ, OP_JC: state_d = S_NEXT;
                    OP_LDI: regs_d[rd] = ir1_q;
                    OP_MOV: regs_d[rd] = regs_q[rs];
                    OP_ALU: begin
                        alu_en  = 1'b1;
                        cnt_d   = 2'd0;
                        state_d = S_ALU_WAIT;
                    end
                    OP_OUT: begin
                        out_valid = 1'b1;
                        out_data  = regs_q[rd];
                    end
                    OP_HLT: state_d = S_HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_ALU_WAIT: begin
                if (cnt_q == ALU_LAST) begin
                    state_d = S_WB;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_WB: begin
                // Flags are only ever updated here.
                regs_d[rd] = alu_res;
                z_d        = alu_zero;
                c_d        = alu_carry;
                state_d    = S_NEXT;
            end
            S_NEXT: begin
                if (step_go) begin
                    if (take_jump) begin
                        pc_jump_en   = 1'b1;
                        pc_jump_addr = ir1_q;
                    end else begin
                        pc_adv        = 1'b1;
                        pc_instr_size = instr_size;
                    end
                    cnt_d   = 2'd0;
                    state_d = S_FETCH;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // ALU operands stay stable from the alu_en pulse through write-back.
    always_comb begin
        alu_a  = 8'h00;
        alu_b  = 8'h00;
        alu_op = 3'd0;
        if ((state_q == S_EXEC || state_q == S_ALU_WAIT || state_q == S_WB) &&
            opcode == OP_ALU) begin
            alu_a  = regs_q[rd];
            alu_b  = regs_q[rs];
            alu_op = ir1_q[2:0];
        end
    end

    assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;

    // State, instruction latch, register file and flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 2'd0;
            start_q   <= 1'b0;
            ir0_q     <= 8'h00;
            ir1_q     <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= 8'h00;
            end
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            ir0_q     <= ir0_d;
            ir1_q     <= ir1_d;
            regs_q    <= regs_d;
            z_q       <= z_d;
            c_q       <= c_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Fetch/decode/execute controller for the 8-bit CPU core.
- Sits between program_counter, pram and alu: reads the instruction bytes presented by pram and drives PC advance/jump and ALU operand/op/enable.
- Holds a 4-entry 8-bit register file (R0-R3) plus Z/C flags.
- Leaves IDLE only once the flash loader reports the program loaded and a start pulse arrives.

Parameters:
- FETCH_WAIT, 1, cycles between a PC update and the pram instruction bytes being valid (1..3).
- ALU_LAT, 1, cycles from the alu_en pulse to alu_res/flags being valid (1..3).

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  run request (debounced btn2); level, edge-detected internally.
- load_done  in  1  program image loaded into pram.
- instr_b0, instr_b1  in  8 each  instruction bytes 0/1 from pram.
- alu_res  in  8  ALU result.
- alu_carry, alu_zero  in  1 each  ALU flags.
- pc_adv  out  1  one-cycle pulse: PC += pc_instr_size.
- pc_instr_size  out  2  size of the current instruction (1 or 2).
- pc_jump_en  out  1  one-cycle pulse: PC := pc_jump_addr.
- pc_jump_addr  out  8  jump target.
- alu_en  out  1  one-cycle pulse starting an ALU operation.
- alu_a, alu_b  out  8 each  ALU operands.
- alu_op  out  3  ALU operation code.
- out_data  out  8  OUT instruction data (to leds).
- out_valid  out  1  one-cycle pulse with out_data.
- busy  out  1  high in any state except IDLE/HALT.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; set on an undefined opcode.

Behaviour:
- Encoding: b0[7:4]=opcode, b0[3:2]=rd, b0[1:0]=rs.
- Opcodes:
  - 0x0 NOP (size 1).
  - 0x1 LDI rd,b1 (size 2).
  - 0x2 MOV rd,rs (size 1).
  - 0x3 ALU rd,rs (size 2): alu_a=R[rd], alu_b=R[rs], alu_op=b1[2:0], result to rd.
  - 0x4 JMP b1 (size 2).
  - 0x5 JZ b1 (size 2).
  - 0x6 JC b1 (size 2).
  - 0x7 OUT rd (size 1).
  - 0xF HLT (size 1).
  - All other opcodes are illegal.
- States:
  - IDLE.
  - FETCH: FETCH_WAIT cycles.
  - DECODE: 1 cycle; latches b0/b1.
  - EXEC: 1 cycle.
  - ALU_WAIT: ALU_LAT cycles.
  - WB: 1 cycle.
  - NEXT: 1 cycle.
  - HALT.
- Transitions:
  - IDLE->FETCH on a rising edge of start while load_done=1. Start edges with load_done=0 are dropped.
  - EXEC->ALU_WAIT for ALU; otherwise EXEC->NEXT.
  - ALU_WAIT->WB->NEXT.
  - NEXT->FETCH.
  - EXEC->HALT on HLT or an illegal opcode.
- EXEC actions:
  - LDI/MOV write rd.
  - OUT drives out_data=R[rd] and pulses out_valid.
  - ALU pulses alu_en with operands/op held stable until WB.
- WB: R[rd]:=alu_res, Z:=alu_zero, C:=alu_carry. Flags change only in WB.
- NEXT: exactly one of pc_adv or pc_jump_en pulses.
  - Jump: JMP always; JZ when Z=1; JC when C=1; pc_jump_addr=b1.
  - Otherwise pc_adv with pc_instr_size.
- Latency with FETCH_WAIT=1, ALU_LAT=1, from one NEXT to the next: non-ALU instruction 4 cycles; ALU instruction 6 cycles.
- A start edge while busy or halted is ignored.
- HALT is left only via reset.
- An illegal opcode sets illegal=1 and halted=1; no PC pulse is issued.
- Writes to rd=rs (MOV R1,R1) are legal and are a no-op.
- Reset values (rst=0 at posedge, from any state including mid-ALU_WAIT): state IDLE, R0-R3=0, Z=C=0, every output 0, pc_instr_size=0. Any in-flight ALU result is discarded.
- PC wrap-around is owned by program_counter; the sequencer does not check it.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input port step (1 bit).
  - NEXT waits until a rising edge of step before issuing its PC pulse and moving to FETCH.
  - busy stays high while waiting.
  - A step edge seen in the same cycle NEXT is entered counts.
- When undefined: no step port; NEXT never waits.

Test Plan:
- load_done=0 then start edge -> remains IDLE, busy=0. Set load_done=1, start edge -> FETCH on the next cycle, busy=1.
- Program LDI R1,0x05; LDI R2,0x03; ALU R1,R2 op=ADD; OUT R1 -> out_valid pulse with out_data=0x08; pc_adv pulses with sizes 2,2,2,1; alu_en pulses exactly once.
- ALU result 0x00 with alu_zero=1, then JZ 0x10 -> pc_jump_en pulse with pc_jump_addr=0x10, no pc_adv. Repeat with Z=0 -> pc_adv with size 2.
- Opcode 0xA -> illegal=1, halted=1, no PC pulse; further start edges ignored; rst=0 for one cycle -> all outputs 0, state IDLE.
- rst=0 asserted during ALU_WAIT -> the next cycle shows alu_en=0, busy=0, R[rd] unchanged from reset (0x00).
- With SEQ_SINGLE_STEP_EN: NOP program -> no pc_adv until a step edge; each step edge produces exactly one pc_adv pulse.
